// File: rtl/lenet_pkg.sv
// Shared types and defaults for the LeNet argmax classifier stage.
package lenet_pkg;

  localparam int BITWIDTH_DEF    = 8;
  localparam int NUM_CLASSES_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } argmax_state_t;

  typedef logic signed [BITWIDTH_DEF-1:0] logit_t;

endpackage

// File: rtl/lenet_argmax_cmp.sv
// Combinational compare/update cell: a candidate logit replaces the base entry
// when it is strictly greater, or when the base entry is not yet valid.
module lenet_argmax_cmp #(
  parameter int BITWIDTH = 8,
  parameter int IDX_W    = 4
) (
  input  logic signed [BITWIDTH-1:0] cand_score,
  input  logic        [IDX_W-1:0]    cand_idx,
  input  logic signed [BITWIDTH-1:0] base_score,
  input  logic        [IDX_W-1:0]    base_idx,
  input  logic                       base_vld,
  output logic signed [BITWIDTH-1:0] nxt_score,
  output logic        [IDX_W-1:0]    nxt_idx
);

  logic take;

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to remember the old value.
    take      = 1'b0;
    nxt_score = base_score;
    nxt_idx   = base_idx;
    // Strict compare: on a tie the earlier (lower) index keeps its place.
    if (!base_vld || (cand_score > base_score)) begin
      take = 1'b1;
    end
    if (take) begin
      nxt_score = cand_score;
      nxt_idx   = cand_idx;
    end
  end

endmodule

// File: rtl/lenet_argmax_classifier.sv
// Final LeNet stage: captures the logit vector, scans it one entry per cycle
// and reports the winning class. Optional top-2 outputs: LENET_ARGMAX_TOP2_EN.
module lenet_argmax_classifier
  import lenet_pkg::*;
#(
  parameter  int BITWIDTH    = BITWIDTH_DEF,
  parameter  int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter  int CNT_W       = 16,
  localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BITWIDTH-1:0] featuremap3 [NUM_CLASSES-1:0],
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic        [IDX_W-1:0]    class_idx,
  output logic signed [BITWIDTH-1:0] class_score,
  output logic        [CNT_W-1:0]    frame_cnt
`ifdef LENET_ARGMAX_TOP2_EN
  ,
  output logic        [IDX_W-1:0]    second_idx,
  output logic        [BITWIDTH:0]   margin
`endif
);

  if (NUM_CLASSES < 2) begin : g_bad_cfg
    $error("lenet_argmax_classifier: NUM_CLASSES must be at least 2");
  end

  argmax_state_t              state;
  logic signed [BITWIDTH-1:0] bank [NUM_CLASSES];
  logic        [IDX_W-1:0]    ptr;
  logic signed [BITWIDTH-1:0] best_score;
  logic        [IDX_W-1:0]    best_idx;
  logic signed [BITWIDTH-1:0] nxt_best_score;
  logic        [IDX_W-1:0]    nxt_best_idx;
  logic signed [BITWIDTH-1:0] cand_score;
  logic                       last_entry;

  assign cand_score = bank[ptr];
  assign last_entry = (ptr == IDX_W'(NUM_CLASSES - 1));

  lenet_argmax_cmp #(
    .BITWIDTH (BITWIDTH),
    .IDX_W    (IDX_W)
  ) u_cmp_best (
    .cand_score (cand_score),
    .cand_idx   (ptr),
    .base_score (best_score),
    .base_idx   (best_idx),
    .base_vld   (1'b1),
    .nxt_score  (nxt_best_score),
    .nxt_idx    (nxt_best_idx)
  );

`ifdef LENET_ARGMAX_TOP2_EN
  logic signed [BITWIDTH-1:0] run_second_score;
  logic        [IDX_W-1:0]    run_second_idx;
  logic                       run_second_vld;
  logic signed [BITWIDTH-1:0] cmp_second_score;
  logic        [IDX_W-1:0]    cmp_second_idx;
  logic signed [BITWIDTH-1:0] nxt_second_score;
  logic        [IDX_W-1:0]    nxt_second_idx;
  logic                       best_taken;
  logic        [BITWIDTH:0]   nxt_margin;

  lenet_argmax_cmp #(
    .BITWIDTH (BITWIDTH),
    .IDX_W    (IDX_W)
  ) u_cmp_second (
    .cand_score (cand_score),
    .cand_idx   (ptr),
    .base_score (run_second_score),
    .base_idx   (run_second_idx),
    .base_vld   (run_second_vld),
    .nxt_score  (cmp_second_score),
    .nxt_idx    (cmp_second_idx)
  );

  // The running best always sits below ptr, so a best index equal to ptr
  // means the candidate just displaced it and the old best is demoted.
  assign best_taken = (nxt_best_idx == ptr);

  always_comb begin
    nxt_second_score = cmp_second_score;
    nxt_second_idx   = cmp_second_idx;
    if (best_taken) begin
      nxt_second_score = best_score;
      nxt_second_idx   = best_idx;
    end
    nxt_margin = {nxt_best_score[BITWIDTH-1], nxt_best_score}
               - {nxt_second_score[BITWIDTH-1], nxt_second_score};
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      frame_cnt   <= '0;
      ptr         <= '0;
      best_score  <= '0;
      best_idx    <= '0;
      // NOTE: the logit bank is small and reset-cleared on purpose so an
      // aborted frame never leaves stale logits behind.
      for (int i = 0; i < NUM_CLASSES; i++) begin
        bank[i] <= '0;
      end
`ifdef LENET_ARGMAX_TOP2_EN
      run_second_score <= '0;
      run_second_idx   <= '0;
      run_second_vld   <= 1'b0;
      second_idx       <= '0;
      margin           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
              bank[i] <= featuremap3[i];
            end
            best_score <= featuremap3[0];
            best_idx   <= '0;
            ptr        <= IDX_W'(1);
            in_ready   <= 1'b0;
            state      <= SCAN;
`ifdef LENET_ARGMAX_TOP2_EN
            run_second_vld <= 1'b0;
`endif
          end
        end

        SCAN: begin
          best_score <= nxt_best_score;
          best_idx   <= nxt_best_idx;
          ptr        <= ptr + 1'b1;
`ifdef LENET_ARGMAX_TOP2_EN
          run_second_score <= nxt_second_score;
          run_second_idx   <= nxt_second_idx;
          run_second_vld   <= 1'b1;
`endif
          if (last_entry) begin
            out_valid   <= 1'b1;
            class_idx   <= nxt_best_idx;
            class_score <= nxt_best_score;
            state       <= DONE;
`ifdef LENET_ARGMAX_TOP2_EN
            second_idx <= nxt_second_idx;
            margin     <= nxt_margin;
`endif
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lenet_argmax_classifier.sv
// Self-checking bench for lenet_argmax_classifier against a plain argmax model.
`timescale 1ns/1ps
module tb_lenet_argmax_classifier;

  localparam int BW = 8;
  localparam int NC = 10;
  localparam int IW = $clog2(NC);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 out_ready;
  logic signed [BW-1:0] featuremap3 [NC-1:0];

  logic                 in_ready;
  logic                 out_valid;
  logic        [IW-1:0] class_idx;
  logic signed [BW-1:0] class_score;
  logic        [15:0]   frame_cnt;

  logic                 in_ready_w;
  logic                 out_valid_w;
  logic        [IW-1:0] class_idx_w;
  logic signed [BW-1:0] class_score_w;
  logic        [3:0]    frame_cnt_w;

`ifdef LENET_ARGMAX_TOP2_EN
  logic [IW-1:0] second_idx, second_idx_w;
  logic [BW:0]   margin, margin_w;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int edges    = 0;
  int exp_frames;
  int vec [NC];
  int m_idx, m_best, m_second_idx, m_margin;

  always #5 clk = ~clk;

  lenet_argmax_classifier #(.BITWIDTH(BW), .NUM_CLASSES(NC), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .featuremap3 (featuremap3),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .class_idx   (class_idx),
    .class_score (class_score),
    .frame_cnt   (frame_cnt)
`ifdef LENET_ARGMAX_TOP2_EN
    ,
    .second_idx  (second_idx),
    .margin      (margin)
`endif
  );

  // Narrow-counter twin so the frame counter wrap is reachable in a short run.
  lenet_argmax_classifier #(.BITWIDTH(BW), .NUM_CLASSES(NC), .CNT_W(4)) dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready_w),
    .featuremap3 (featuremap3),
    .out_valid   (out_valid_w),
    .out_ready   (out_ready),
    .class_idx   (class_idx_w),
    .class_score (class_score_w),
    .frame_cnt   (frame_cnt_w)
`ifdef LENET_ARGMAX_TOP2_EN
    ,
    .second_idx  (second_idx_w),
    .margin      (margin_w)
`endif
  );

  task automatic step();
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: first index holding the maximum; runner-up is the first
  // index holding the maximum among all other entries.
  function automatic void model();
    m_idx = 0;
    for (int i = 1; i < NC; i++) if (vec[i] > vec[m_idx]) m_idx = i;
    m_second_idx = -1;
    for (int i = 0; i < NC; i++)
      if (i != m_idx && (m_second_idx < 0 || vec[i] > vec[m_second_idx])) m_second_idx = i;
    m_best   = vec[m_idx];
    m_margin = m_best - vec[m_second_idx];
  endfunction

  task automatic rand_vec(input int lo, input int hi);
    for (int i = 0; i < NC; i++) vec[i] = lo + int'($urandom_range(0, hi - lo));
  endtask

  task automatic drive_vec();
    for (int i = 0; i < NC; i++) featuremap3[i] = BW'(vec[i]);
  endtask

  task automatic check_result(input string tag);
    check({tag, " class_idx"}, class_idx, m_idx);
    check({tag, " class_score"}, class_score, m_best);
`ifdef LENET_ARGMAX_TOP2_EN
    check({tag, " second_idx"}, second_idx, m_second_idx);
    check({tag, " margin"}, margin, m_margin);
`endif
  endtask

  task automatic do_frame(input string tag, input int hold);
    int w, lat;
    logic [IW-1:0]    prev_idx;
    logic [BW-1:0]    prev_score;
    model();
    drive_vec();
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin step(); w++; end
    check({tag, " in_ready before accept"}, in_ready, 1);
    prev_idx   = class_idx;
    prev_score = class_score;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < NC; i++) featuremap3[i] = BW'($urandom);
    check({tag, " in_ready in scan"}, in_ready, 0);
    check({tag, " idx held in scan"}, class_idx, prev_idx);
    check({tag, " score held in scan"}, {56'd0, prev_score}, {56'd0, class_score});
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
    check({tag, " latency"}, lat, NC - 1);
    check_result(tag);
    check({tag, " frame_cnt before"}, frame_cnt, exp_frames);
    for (int k = 0; k < hold; k++) begin
      step();
      check({tag, " hold out_valid"}, out_valid, 1);
      check({tag, " hold in_ready"}, in_ready, 0);
      check({tag, " hold class_idx"}, class_idx, m_idx);
      check({tag, " hold class_score"}, class_score, m_best);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_frames++;
    check({tag, " out_valid after accept"}, out_valid, 0);
    check({tag, " in_ready after accept"}, in_ready, 1);
    check({tag, " frame_cnt after"}, frame_cnt, exp_frames);
    check({tag, " idx held in idle"}, class_idx, m_idx);
  endtask

  initial begin
    int w, lat, last_accept;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    exp_frames = 0;
    for (int i = 0; i < NC; i++) featuremap3[i] = '0;

    repeat (2) step();
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset class_idx", class_idx, 0);
    check("reset class_score", class_score, 0);
    check("reset frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    step();
    check("in_ready after reset", in_ready, 1);

    vec = '{3, -5, 7, 7, 2, 0, -128, 1, 6, -1};
    do_frame("tie_low_index", 0);
    check("tie_low_index idx", m_idx, 2);

    for (int i = 0; i < NC; i++) vec[i] = -128;
    do_frame("all_min", 0);

    for (int i = 0; i < NC; i++) vec[i] = 0;
    vec[NC-1] = 127;
    do_frame("max_last_backpressure", 20);

    vec = '{10, 50, -3, 49, 0, 0, 0, 0, 0, 0};
    do_frame("top2_directed", 2);

    for (int f = 0; f < 4; f++) begin
      rand_vec(-128, 127);
      do_frame("random_full", int'($urandom_range(0, 3)));
      rand_vec(-2, 2);
      do_frame("random_ties", 0);
    end

    // Asynchronous abort in the middle of a scan.
    rand_vec(20, 100);
    drive_vec();
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin step(); w++; end
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check("abort in_ready", in_ready, 0);
    check("abort out_valid", out_valid, 0);
    check("abort class_idx", class_idx, 0);
    check("abort class_score", class_score, 0);
    check("abort frame_cnt", frame_cnt, 0);
    #3 rst_n = 1'b1;
    exp_frames = 0;
    step();

    vec[0] = 9;
    for (int i = 1; i < NC; i++) vec[i] = -128 + int'($urandom_range(0, 137));
    vec[1] = 1;
    do_frame("after_abort", 0);

    // Back-to-back frames with both handshakes held high.
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    last_accept = 0;
    for (int f = 0; f < 16; f++) begin
      rand_vec(-128, 127);
      model();
      drive_vec();
      w = 0;
      while (!in_ready && w < 50) begin step(); w++; end
      check("b2b in_ready", in_ready, 1);
      if (f > 0) check("b2b accept spacing", edges + 1 - last_accept, NC + 1);
      last_accept = edges + 1;
      step();
      lat = 0;
      while (!out_valid && lat < 50) begin step(); lat++; end
      check("b2b latency", lat, NC - 1);
      check_result("b2b");
      check("b2b twin class_idx", class_idx_w, m_idx);
      step();
      exp_frames++;
      check("b2b frame_cnt", frame_cnt, exp_frames);
      check("b2b frame_cnt wrap", frame_cnt_w, exp_frames % 16);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    check("final out_valid_w", out_valid_w, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
